// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the group width of the borrow-lookahead subtractor.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int GROUP_W = 4;

endpackage

// File: rtl/seq_restoring_divider_sub.sv
// Combinational N-bit subtractor diff = a - b - borrow_in with borrow lookahead
// over 4-bit groups; borrow_out set when the result underflows.
module borrow_lookahead_sub
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = 9
) (
    output logic [N-1:0] diff,
    output logic         borrow_out,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in
);

    localparam int NG = (N + GROUP_W - 1) / GROUP_W;

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_bin;
    logic         w_bout;

    // Borrow generated where a=0,b=1; an incoming borrow passes where a==b.
    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    // Each bit's borrow-in is the group prefix generate OR prefix propagate AND
    // the group borrow-in, so no bit waits on its lower neighbour's borrow.
    always_comb begin
        logic c, gg, gp;
        w_bin = '0;
        c     = borrow_in;
        gg    = 1'b0;
        gp    = 1'b1;
        for (int gi = 0; gi < NG; gi++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < GROUP_W; j++) begin
                if (gi * GROUP_W + j < N) begin
                    w_bin[gi*GROUP_W+j] = gg | (gp & c);
                    gg = w_g[gi*GROUP_W+j] | (w_p[gi*GROUP_W+j] & gg);
                    gp = gp & w_p[gi*GROUP_W+j];
                end
            end
            c = gg | (gp & c);
        end
        w_bout = c;
    end

    assign diff       = a ^ b ^ w_bin;
    assign borrow_out = w_bout;

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first,
// with valid/ready handshakes on input and result.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_qsh;
    logic             r_dbz;
    logic             r_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz_out;

    logic [WIDTH:0]   w_pshift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_next_p;
    logic             w_borrow;
    logic             w_unused_pmsb;

    assign w_pshift = {r_p[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_next_p = w_borrow ? w_pshift : w_diff;
    // After a restoring step P < divisor, so its top bit never feeds the next shift.
    assign w_unused_pmsb = r_p[WIDTH];

    borrow_lookahead_sub #(.N(WIDTH + 1)) u_sub (
        .diff       (w_diff),
        .borrow_out (w_borrow),
        .a          (w_pshift),
        .b          ({1'b0, r_dvs}),
        .borrow_in  (1'b0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_p       <= '0;
            r_qsh     <= '0;
            r_dbz     <= 1'b0;
            r_valid   <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                        r_p   <= '0;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            r_dbz   <= 1'b1;
                            r_qsh   <= '1;
                            r_state <= ST_DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_qsh   <= '0;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_p   <= w_next_p;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_qsh <= {r_qsh[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle loads the result; later ones wait for the consumer.
                    if (!r_valid) begin
                        r_valid   <= 1'b1;
                        r_quot    <= r_qsh;
                        r_rem     <= r_dbz ? r_dvd : r_p[WIDTH-1:0];
                        r_dbz_out <= r_dbz;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE) & ~rst;
    assign out_valid   = r_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and light random checks of the restoring divider: latency, results,
// divide-by-zero, back-pressure, reset mid-operation and back-to-back operation.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Accept one operation (caller guarantees in_ready), wait for the result,
    // hold out_ready low for 'hold' cycles, then take it.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         output int lat, output logic [7:0] q, output logic [7:0] r,
                         output logic z);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h3C;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (quotient !== 8'h00) begin errs++; $display("FAIL reset_quotient got=%h exp=00", quotient); end
        checks++; if (remainder !== 8'h00) begin errs++; $display("FAIL reset_remainder got=%h exp=00", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] q, r; logic z;
        do_op(8'd100, 8'd7, 0, lat, q, r, z);
        checks++; if (lat !== 9) begin errs++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        checks++; if (q !== 8'd14) begin errs++; $display("FAIL basic_quotient got=%0d exp=14", q); end
        checks++; if (r !== 8'd2) begin errs++; $display("FAIL basic_remainder got=%0d exp=2", r); end
        checks++; if (z !== 1'b0) begin errs++; $display("FAIL basic_dbz got=%b exp=0", z); end
    endtask

    task automatic test_boundaries();
        logic [7:0] va [4] = '{8'd255, 8'd3,   8'd255, 8'd0};
        logic [7:0] vb [4] = '{8'd1,   8'd200, 8'd255, 8'd9};
        logic [7:0] vq [4] = '{8'd255, 8'd0,   8'd1,   8'd0};
        logic [7:0] vr [4] = '{8'd0,   8'd3,   8'd0,   8'd0};
        int lat; logic [7:0] q, r; logic z;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 0, lat, q, r, z);
            checks++; if (lat !== 9) begin errs++; $display("FAIL bound%0d_latency got=%0d exp=9", i, lat); end
            checks++; if (q !== vq[i]) begin errs++; $display("FAIL bound%0d_quotient got=%0d exp=%0d", i, q, vq[i]); end
            checks++; if (r !== vr[i]) begin errs++; $display("FAIL bound%0d_remainder got=%0d exp=%0d", i, r, vr[i]); end
            checks++; if (z !== 1'b0) begin errs++; $display("FAIL bound%0d_dbz got=%b exp=0", i, z); end
        end
    endtask

    task automatic test_div_zero();
        in_valid = 1'b1; dividend = 8'd5; divisor = 8'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL dbz_early_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL dbz_valid got=%b exp=1", out_valid); end
        checks++; if (quotient !== 8'hFF) begin errs++; $display("FAIL dbz_quotient got=%h exp=ff", quotient); end
        checks++; if (remainder !== 8'h05) begin errs++; $display("FAIL dbz_remainder got=%h exp=05", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errs++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL dbz_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL dbz_taken_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1; dividend = 8'd77; divisor = 8'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 9) begin errs++; $display("FAIL bp_latency got=%0d exp=9", lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 8'd200; divisor = 8'd3;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || quotient !== 8'd15 || remainder !== 8'd2)
                begin errs++; $display("FAIL bp_hold%0d got=v%b q%0d r%0d exp=v1 q15 r2", i, out_valid, quotient, remainder); end
            checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (quotient !== 8'd15) begin errs++; $display("FAIL bp_keep_quotient got=%0d exp=15", quotient); end
    endtask

    task automatic test_reset_mid_calc();
        int lat; logic [7:0] q, r; logic z;
        in_valid = 1'b1; dividend = 8'd150; divisor = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0)
            begin errs++; $display("FAIL rstmid_outputs got=v%b q%0d r%0d exp=v0 q0 r0", out_valid, quotient, remainder); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        do_op(8'd200, 8'd13, 0, lat, q, r, z);
        checks++; if (lat !== 9 || q !== 8'd15 || r !== 8'd5)
            begin errs++; $display("FAIL rstmid_followup got=lat%0d q%0d r%0d exp=lat9 q15 r5", lat, q, r); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] q, r; logic z;
        do_op(8'd60, 8'd7, 0, lat, q, r, z);
        checks++; if (q !== 8'd8 || r !== 8'd4) begin errs++; $display("FAIL b2b_first got=q%0d r%0d exp=q8 r4", q, r); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        do_op(8'd9, 8'd3, 0, lat, q, r, z);
        checks++; if (lat !== 9 || q !== 8'd3 || r !== 8'd0)
            begin errs++; $display("FAIL b2b_second got=lat%0d q%0d r%0d exp=lat9 q3 r0", lat, q, r); end
    endtask

    task automatic test_random();
        int lat, exp_lat; logic [7:0] q, r, a, b, eq, er; logic z;
        for (int n = 0; n < 200; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            exp_lat = (b == 0) ? 1 : 9;
            eq = (b == 0) ? 8'hFF : a / b;
            er = (b == 0) ? a : a % b;
            do_op(a, b, $urandom_range(0, 3), lat, q, r, z);
            checks++; if (lat !== exp_lat || q !== eq || r !== er || z !== (b == 0))
                begin errs++; $display("FAIL rand%0d %0d/%0d got=lat%0d q%0d r%0d z%b exp=lat%0d q%0d r%0d",
                                       n, a, b, lat, q, r, z, exp_lat, eq, er); end
            if (b != 0) begin
                checks++; if ((int'(q) * int'(b) + int'(r)) != int'(a) || r >= b)
                    begin errs++; $display("FAIL rand%0d_invariant %0d/%0d got=q%0d r%0d", n, a, b, q, r); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
